// File: rtl/col_packer_pkg.sv
// Shared CNN definitions for the column packer: state encoding and fixed map height.
package col_packer_pkg;

  localparam int MAT_H = 2;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } pack_state_e;

endpackage

// File: rtl/col_packer.sv
// Collects a 2 x MAT_W tile per feature map in row-major order, then replays it
// column by column (row 0 and row 1 side by side) to the reduction stage.
module col_packer
  import col_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_MATS     = 10,
  parameter int MAT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pixel  [N_MATS],
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] column [N_MATS][MAT_H],
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int CW = (MAT_W > 1) ? $clog2(MAT_W) : 1;

  pack_state_e state, state_nxt;
  logic [CW-1:0] col_cnt;
  logic          row_cnt;
  logic          accept;
  logic          col_last;
  logic          fill_last;
  logic          drain_last;

  logic [DATA_WIDTH-1:0] buffer [MAT_H][MAT_W][N_MATS];

  assign ready_out  = (state == FILL);
  assign accept     = valid_in && ready_out;
  assign col_last   = (col_cnt == CW'(MAT_W - 1));
  assign fill_last  = accept && row_cnt && col_last;
  assign drain_last = (state == DRAIN) && col_last;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_last) state_nxt = DRAIN;
      DRAIN:   if (col_last)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // One counter pair serves both phases: write position in FILL, read column in DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= 1'b0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= ~row_cnt;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end else if (state == DRAIN) begin
      col_cnt <= col_last ? '0 : col_cnt + 1'b1;
    end
  end

  // Tile storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int m = 0; m < N_MATS; m++) begin
        buffer[row_cnt][col_cnt][m] <= pixel[m];
      end
    end
  end

  // Output register stage: column k lands one cycle after drain step k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int m = 0; m < N_MATS; m++) begin
        for (int r = 0; r < MAT_H; r++) begin
          column[m][r] <= '0;
        end
      end
    end else begin
      valid_out  <= (state == DRAIN);
      frame_done <= drain_last;
      overflow   <= overflow | (valid_in & ~ready_out);
      if (state == DRAIN) begin
        for (int m = 0; m < N_MATS; m++) begin
          for (int r = 0; r < MAT_H; r++) begin
            column[m][r] <= buffer[r][col_cnt][m];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_col_packer.sv
// Scoreboard bench for col_packer: default instance (MAT_W=2) and a MAT_W=4 instance.
module tb_col_packer;
  import col_packer_pkg::*;

  localparam int DW = 16;
  localparam int NM = 10;

  typedef logic [NM-1:0][1:0][DW-1:0] colvec_t;
  typedef struct packed {
    int unsigned cyc;
    logic        fd;
    colvec_t     d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vin0 = 1'b0, vin1 = 1'b0;
  logic [DW-1:0] pix0 [NM];
  logic [DW-1:0] pix1 [NM];
  logic rdy0, vo0, fd0, ovf0;
  logic rdy1, vo1, fd1, ovf1;
  logic [DW-1:0] col0 [NM][2];
  logic [DW-1:0] col1 [NM][2];

  col_packer #(.DATA_WIDTH(DW), .N_MATS(NM), .MAT_W(2)) dut0 (
    .clk(clk), .rst(rst), .valid_in(vin0), .pixel(pix0), .ready_out(rdy0),
    .valid_out(vo0), .column(col0), .frame_done(fd0), .overflow(ovf0)
  );

  col_packer #(.DATA_WIDTH(DW), .N_MATS(NM), .MAT_W(4)) dut1 (
    .clk(clk), .rst(rst), .valid_in(vin1), .pixel(pix1), .ready_out(rdy1),
    .valid_out(vo1), .column(col1), .frame_done(fd1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned ecnt = 0;
  bit mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model: tile contents, accepted-beat count, busy cycles, sticky overflow.
  logic [DW-1:0] mbuf [2][2][4][NM];
  logic [DW-1:0] drv_d [2][NM];
  int mcnt [2];
  int mbusy [2];
  bit movf [2];
  int ncols [2];
  int nfd [2];

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int wof(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic colvec_t pack(input int i);
    colvec_t v;
    for (int m = 0; m < NM; m++)
      for (int r = 0; r < 2; r++)
        v[m][r] = (i == 0) ? col0[m][r] : col1[m][r];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic mon(input int i, input logic vo, input logic fd, input colvec_t act);
    exp_t e;
    if (vo !== 1'b1) begin
      chk($sformatf("frame_done_idle%0d", i), fd, 0);
      return;
    end
    ncols[i]++;
    if (fd === 1'b1) nfd[i]++;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_column%0d: valid_out=1, required 0 (cycle %0d)", i, ecnt);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("column_cycle%0d", i), ecnt, e.cyc);
    chk($sformatf("frame_done%0d", i), fd, e.fd);
    checks++;
    if (act !== e.d) begin
      errors++;
      $display("FAIL column_data%0d: got %h, required %h", i, act, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon(0, vo0, fd0, pack(0));
      mon(1, vo1, fd1, pack(1));
    end
  end

  task automatic model_edge(input int i, input bit v);
    int  w;
    bit  rdym;
    exp_t e;
    w    = wof(i);
    rdym = (mbusy[i] == 0);
    if (v && rdym) begin
      for (int m = 0; m < NM; m++) mbuf[i][mcnt[i] / w][mcnt[i] % w][m] = drv_d[i][m];
      mcnt[i]++;
    end else if (v) begin
      movf[i] = 1'b1;
    end
    if (!rdym) mbusy[i]--;
    if (mcnt[i] == 2 * w) begin
      for (int k = 0; k < w; k++) begin
        e.cyc = ecnt + 1 + k;
        e.fd  = (k == w - 1);
        for (int m = 0; m < NM; m++) begin
          e.d[m][0] = mbuf[i][0][k][m];
          e.d[m][1] = mbuf[i][1][k][m];
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      mcnt[i]  = 0;
      mbusy[i] = w;
    end
  endtask

  // One clock cycle: drive instance ti, check handshake flags, advance the model.
  task automatic step(input int ti, input bit v, input bit pat, input logic [DW-1:0] base);
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < NM; m++) begin
        drv_d[i][m] = pat ? base + DW'(100 * m + 10 * (mcnt[i] / wof(i)) + (mcnt[i] % wof(i)))
                          : DW'($urandom);
      end
    end
    for (int m = 0; m < NM; m++) begin
      pix0[m] = drv_d[0][m];
      pix1[m] = drv_d[1][m];
    end
    vin0 = (ti == 0) && v;
    vin1 = (ti == 1) && v;
    @(negedge clk);
    chk("ready_out0", rdy0, mbusy[0] == 0);
    chk("ready_out1", rdy1, mbusy[1] == 0);
    chk("overflow0", ovf0, movf[0]);
    chk("overflow1", ovf1, movf[1]);
    @(posedge clk);
    #1;
    model_edge(0, (ti == 0) && v);
    model_edge(1, (ti == 1) && v);
  endtask

  task automatic do_reset();
    vin0 = 1'b0;
    vin1 = 1'b0;
    rst  = 1'b1;
    #2;
    chk("rst_ready0", rdy0, 1);
    chk("rst_ready1", rdy1, 1);
    chk("rst_valid0", vo0, 0);
    chk("rst_valid1", vo1, 0);
    chk("rst_done0", fd0, 0);
    chk("rst_done1", fd1, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_ovf1", ovf1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pack(i) !== '0) begin
        errors++;
        $display("FAIL rst_column%0d: got %h, required 0", i, pack(i));
      end
      mcnt[i]  = 0;
      mbusy[i] = 0;
      movf[i]  = 1'b0;
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, c0;
    for (int m = 0; m < NM; m++) begin
      pix0[m] = '0;
      pix1[m] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Back-to-back pattern frame, then gapped beats of the same pattern.
    for (int b = 0; b < 4; b++) step(0, 1, 1, 16'd0);
    repeat (4) step(0, 0, 1, 16'd0);
    for (int b = 0; b < 4; b++) begin
      step(0, 1, 1, 16'd0);
      repeat (3) step(0, 0, 1, 16'd0);
    end
    repeat (3) step(0, 0, 0, 16'd0);

    // valid_in held high through drain: beats dropped, overflow sticks.
    repeat (14) step(0, 1, 0, 16'd0);
    repeat (4) step(0, 0, 0, 16'd0);

    // Reset after three beats, then a fresh frame.
    do_reset();
    repeat (3) step(0, 1, 1, 16'h1000);
    do_reset();
    for (int b = 0; b < 4; b++) step(0, 1, 1, 16'h2000);
    repeat (4) step(0, 0, 1, 16'd0);

    // MAT_W=4: three back-to-back frames.
    f0 = nfd[1];
    c0 = ncols[1];
    for (int c = 0; c < 36; c++) step(1, mbusy[1] == 0, 1, 16'h3000 + DW'(c / 12) * 16'h0100);
    repeat (4) step(1, 0, 0, 16'd0);
    chk("frames_w4", nfd[1] - f0, 3);
    chk("columns_w4", ncols[1] - c0, 12);

    // Random traffic on both instances, with a reset during a drain.
    for (int c = 0; c < 300; c++) step($urandom_range(0, 1), $urandom_range(0, 99) < 60, 0, 16'd0);
    repeat (8) step(0, 0, 0, 16'd0);
    for (int b = 0; b < 4; b++) step(0, 1, 0, 16'd0);
    step(0, 0, 0, 16'd0);
    do_reset();
    for (int c = 0; c < 200; c++) step($urandom_range(0, 1), $urandom_range(0, 99) < 70, 0, 16'd0);
    repeat (10) step(0, 0, 0, 16'd0);

    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/col_packer.md
COL_PACKER -- requirements
Module: col_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one feature-map element.
REQ-002 Parameter N_MATS, default 10, number of parallel feature maps (one per digit class).
REQ-003 Parameter MAT_W, default 2, columns per feature map; map height is fixed at 2 rows.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  pixel[] carries one element per map this cycle.
REQ-007 pixel  input  [DATA_WIDTH-1:0] x N_MATS  one element per map; arrival order is row-major (row 0 cols 0..MAT_W-1, then row 1).
REQ-008 ready_out  output  1  block accepts pixel[] this cycle.
REQ-009 valid_out  output  1  column[] holds one complete column for all maps.
REQ-010 column  output  [DATA_WIDTH-1:0] x N_MATS x 2  index [m][0] is row 0, [m][1] is row 1, same column position.
REQ-011 frame_done  output  1  single-cycle pulse coincident with the last column of a frame.
REQ-012 overflow  output  1  sticky flag: valid_in was high while ready_out was low.

Function
REQ-013 Two states: FILL and DRAIN; reset state is FILL.
REQ-014 ready_out is 1 exactly when state is FILL, decoded from registered state only.
REQ-015 In FILL, a beat is accepted when valid_in and ready_out are both 1; it is written to buffer[row_cnt][col_cnt] for every map.
REQ-016 col_cnt counts 0..MAT_W-1 per accepted beat and wraps to 0; row_cnt increments on that wrap.
REQ-017 Acceptance of beat (row 1, col MAT_W-1) moves the state to DRAIN next cycle and clears both counters.
REQ-018 In DRAIN, one column is emitted every cycle in order 0..MAT_W-1, with no stalls and no backpressure.
REQ-019 column and valid_out are registered; column k appears the cycle after drain step k is taken, so the first column is valid two cycles after the last pixel is accepted.
REQ-020 frame_done is 1 in the same cycle as valid_out for column MAT_W-1, and 0 otherwise.
REQ-021 After the last drain step the state returns to FILL; ready_out rises the cycle the last column appears.
REQ-022 Cycles with valid_in=0 in FILL hold all counters and the buffer; gaps may occur anywhere inside a frame.
REQ-023 valid_in=1 while ready_out=0 drops the beat, leaves buffer and counters unchanged, and sets overflow.
REQ-024 overflow is cleared only by reset.
REQ-025 When valid_out=0, column holds its last value; consumers qualify it with valid_out.
REQ-026 Data passes bit-exact with no arithmetic, sign change or width change.

Reset
REQ-027 Asserting rst at any time, including mid-fill or mid-drain, immediately sets state=FILL, counters=0, valid_out=0, frame_done=0, overflow=0 and column=0.
REQ-028 The buffer contents need not be reset.
REQ-029 After rst deasserts, the first accepted beat is treated as row 0, column 0 of a new frame.

Structure
REQ-030 The state enum and the fixed row count of 2 live in the shared CNN package; DATA_WIDTH, N_MATS and MAT_W remain module parameters.
REQ-031 The module is a single flat block with no sub-modules; its outputs connect directly to the valid_in and column inputs of the reduction/decision stage.

Verification
REQ-032 Default parameters; feed beats with pixel[m] = 100*m + 10*row + col, valid_in continuously high.
  - Required response: columns [m] = {100m+c, 100m+10+c} for c = 0, 1 appear at +2 and +3 cycles after the fourth beat.
  - frame_done is 1 with c = 1.
  - ready_out is 0 for exactly 2 cycles.
REQ-033 Same data with valid_in low for 3 cycles between each beat -> identical column values and ordering; no overflow.
REQ-034 Hold valid_in high through DRAIN.
  - Required response: overflow=1 from the cycle after the first rejected beat.
  - Emitted columns are unchanged.
  - The next frame starts at row 0, col 0 once ready_out returns.
REQ-035 Assert rst after 3 accepted beats, then feed 4 fresh beats.
  - Required response: no valid_out before the fresh frame.
  - The output contains only fresh values.
REQ-036 MAT_W=4, three back-to-back frames.
  - Required response: 4 valid columns per frame and 3 frame_done pulses.
  - Each frame occupies 12 cycles, i.e. 8 fill + 4 drain.
